// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths and FSM state encoding.
// Imported by fetch_ctrl, fetch_perf_cnt and the CPU top.
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 19;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch and stall event counters for the fetch sequencer; both wrap silently.
// Only instantiated when FETCH_CTRL_PERF_EN is defined.
module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch,
    input  logic             stall,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch) fetch_cnt <= fetch_cnt + CNT_W'(1);
            if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills a valid/ready holding register toward decode.
// Optional perf counters are enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_W     = fetch_pkg::PC_W,
    parameter int INSTR_W  = fetch_pkg::INSTR_W,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt_req,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               if_ready,
    output logic               halted,
`ifdef FETCH_CTRL_PERF_EN
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt,
`endif
    output logic [1:0]         state
);

    // Handshake: the holding register transfers to decode on any edge where
    // if_valid && if_ready; it may be refilled on that same edge (1 instr/cycle).

    fetch_state_t state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ipc_q, ipc_d;
    logic               fetch;
    logic               holding_free;

    // A flushed holding register counts as empty for the halt decision.
    assign holding_free = !valid_q || if_ready || redirect_valid;

    always_comb begin
        state_d = state_q;
        fetch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    state_d = holding_free ? HALT : DRAIN;
                end else begin
                    fetch = !redirect_valid && (!valid_q || if_ready);
                end
            end
            DRAIN: begin
                if (holding_free) state_d = HALT;
            end
            HALT: begin
                if (!halt_req) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end else if (fetch) begin
            pc_d    = pc_q + PC_W'(1);
            valid_d = 1'b1;
            instr_d = mem_instr;
            ipc_d   = pc_q;
        end else if (valid_q && if_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= PC_W'(RESET_PC);
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    assign pc       = pc_q;
    assign if_valid = valid_q;
    assign if_instr = instr_q;
    assign if_pc    = ipc_q;
    assign halted   = (state_q == HALT);
    assign state    = state_q;

`ifdef FETCH_CTRL_PERF_EN
    logic stall;
    assign stall = ((state_q == RUN) || (state_q == DRAIN)) && valid_q && !if_ready;

    fetch_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fetch),
        .stall     (stall),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios push expected {if_pc, if_instr}
// pairs; a negedge monitor pops and compares on every accepted transfer.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int EW = PC_W + INSTR_W;

    logic               clk = 1'b0;
    logic               rst, start, redirect_valid, halt_req, if_ready;
    logic [PC_W-1:0]    pc, redirect_pc, if_pc;
    logic [INSTR_W-1:0] mem_instr, if_instr;
    logic               if_valid, halted;
    logic [1:0]         state;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0]        fetch_cnt, stall_cnt;
`endif

    logic [INSTR_W-1:0] mem [256];
    logic [EW-1:0]      exp_q[$];
    int                 checks = 0;
    int                 fails  = 0;

    assign mem_instr = mem[pc];

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pc             (pc),
        .mem_instr      (mem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .halted         (halted),
`ifdef FETCH_CTRL_PERF_EN
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt),
`endif
        .state          (state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [PC_W-1:0] p, input logic [INSTR_W-1:0] i);
        exp_q.push_back({p, i});
    endtask

    // monitor: one pop per accepted transfer
    always @(negedge clk) begin
        if (!rst && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_xfer: got pc=%0h instr=%0h, expected none", if_pc, if_instr);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("xfer_pc", 32'(if_pc), 32'(e[EW-1:INSTR_W]));
                check("xfer_instr", 32'(if_instr), 32'(e[INSTR_W-1:0]));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        halt_req = 1'b0; if_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = INSTR_W'(19'h40000 | a);
        mem[0] = 19'd1; mem[1] = 19'd2; mem[2] = 19'd3; mem[3] = 19'd4;
        mem[255] = 19'h5A5A5;

        // A: reset state, streaming 1..4, direct halt
        do_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", 32'(if_instr), 32'd0);
        check("rst_ifpc", 32'(if_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        push_exp(8'd0, 19'd1); push_exp(8'd1, 19'd2);
        push_exp(8'd2, 19'd3); push_exp(8'd3, 19'd4);
        if_ready = 1'b1;
        do_start();
        check("start_state", 32'(state), 32'(RUN));
        check("start_valid", 32'(if_valid), 32'd0);
        repeat (4) begin
            tick();
            check("stream_valid", 32'(if_valid), 32'd1);
            check("stream_halted", 32'(halted), 32'd0);
        end
        halt_req = 1'b1;
        tick();
        check("a_halted", 32'(halted), 32'd1);
        check("a_pc", 32'(pc), 32'd4);
        check("a_valid", 32'(if_valid), 32'd0);

        // B: stall while holding instr 2
        do_reset();
        push_exp(8'd0, 19'd1); push_exp(8'd1, 19'd2); push_exp(8'd2, 19'd3);
        if_ready = 1'b1;
        do_start();
        tick();
        tick();
        if_ready = 1'b0;
        repeat (3) begin
            tick();
            check("stall_instr", 32'(if_instr), 32'd2);
            check("stall_pc", 32'(pc), 32'd2);
            check("stall_valid", 32'(if_valid), 32'd1);
        end
`ifdef FETCH_CTRL_PERF_EN
        check("stall_cnt", 32'(stall_cnt), 32'd3);
        check("fetch_cnt", 32'(fetch_cnt), 32'd2);
`endif
        if_ready = 1'b1;
        tick();
        check("release_instr", 32'(if_instr), 32'd3);
        check("release_ifpc", 32'(if_pc), 32'd2);
        halt_req = 1'b1;
        tick();
        check("b_halted", 32'(halted), 32'd1);

        // C: redirect to 0 while stalled on instr 3
        do_reset();
        push_exp(8'd0, 19'd1); push_exp(8'd1, 19'd2); push_exp(8'd0, 19'd1);
        if_ready = 1'b1;
        do_start();
        repeat (3) tick();
        if_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 8'd0;
        tick();
        check("redir_valid", 32'(if_valid), 32'd0);
        check("redir_pc", 32'(pc), 32'd0);
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        tick();
        check("redir_tgt_instr", 32'(if_instr), 32'd1);
        check("redir_tgt_ifpc", 32'(if_pc), 32'd0);
        halt_req = 1'b1;
        tick();

        // D: halt during stall -> DRAIN -> HALT -> resume at frozen pc
        do_reset();
        push_exp(8'd0, 19'd1); push_exp(8'd1, 19'd2); push_exp(8'd2, 19'd3);
        if_ready = 1'b1;
        do_start();
        tick();
        tick();
        if_ready = 1'b0;
        halt_req = 1'b1;
        repeat (2) begin
            tick();
            check("drain_state", 32'(state), 32'(DRAIN));
            check("drain_halted", 32'(halted), 32'd0);
            check("drain_instr", 32'(if_instr), 32'd2);
        end
        if_ready = 1'b1;
        tick();
        check("d_halted", 32'(halted), 32'd1);
        check("d_valid", 32'(if_valid), 32'd0);
        check("d_pc", 32'(pc), 32'd2);
        tick();
        check("d_pc_frozen", 32'(pc), 32'd2);
        halt_req = 1'b0;
        tick();
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_valid", 32'(if_valid), 32'd0);
        tick();
        check("resume_ifpc", 32'(if_pc), 32'd2);
        check("resume_instr", 32'(if_instr), 32'd3);
        halt_req = 1'b1;
        tick();

        // E: start address 255, wrap-around
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 8'd255;
        tick();
        redirect_valid = 1'b0;
        check("idle_redir_pc", 32'(pc), 32'd255);
        check("idle_redir_state", 32'(state), 32'(IDLE));
        push_exp(8'd255, 19'h5A5A5); push_exp(8'd0, 19'd1); push_exp(8'd1, 19'd2);
        if_ready = 1'b1;
        do_start();
        tick();
        check("wrap_pc", 32'(pc), 32'd0);
        tick();
        tick();
        halt_req = 1'b1;
        tick();

        // F: rst mid-stream
        do_reset();
        do_start();
        tick();
        check("f_hold_valid", 32'(if_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("f_valid", 32'(if_valid), 32'd0);
        check("f_pc", 32'(pc), 32'd0);
        check("f_state", 32'(state), 32'(IDLE));
        repeat (2) tick();
        check("f_nofetch_valid", 32'(if_valid), 32'd0);
        check("f_nofetch_pc", 32'(pc), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 19-bit CPU. Owns the program counter that addresses the 256-entry combinational instruction memory and registers each fetched instruction, with its PC, into a valid/ready holding register toward decode. Handles start-up, branch/jump redirects (with flush), stall back-pressure and a drain-then-halt sequence.

## Interface
- PC_W, 8, program-counter / instruction-memory address width
- INSTR_W, 19, instruction width
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; leaves IDLE and begins fetching
- pc  out  PC_W  address to instruction memory (registered PC)
- mem_instr  in  INSTR_W  combinational read data for `pc`
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  PC_W  redirect target
- halt_req  in  1  level; request to stop fetching
- if_valid  out  1  holding register contains an instruction
- if_instr  out  INSTR_W  held instruction
- if_pc  out  PC_W  address of held instruction
- if_ready  in  1  decode accepts holding register this cycle
- halted  out  1  high only in HALT

## Operation
- Reset values: pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, state=IDLE, halted=0.
- States: IDLE, RUN, DRAIN, HALT.
  - IDLE: start=1 -> RUN. No fetches.
  - RUN: halt_req=1 -> DRAIN, or directly to HALT if the holding register is empty or accepted in that cycle.
  - DRAIN: no new fetches; -> HALT once if_valid=0 or if_ready=1.
  - HALT: halt_req=0 -> RUN.
- Fetch: in RUN with halt_req=0, redirect_valid=0 and (!if_valid || if_ready), latch if_instr=mem_instr, if_pc=pc, if_valid=1, pc=pc+1.
- Accept without refill (if_valid && if_ready, no fetch): if_valid=0.
- PC increment is modulo 2^PC_W; 255 wraps to 0 silently.
- Redirect, in any state except reset: pc=redirect_pc and if_valid=0 (flush, regardless of if_ready); no fetch that cycle. The state transition still follows halt_req; a flushed holding register counts as empty, so RUN+halt_req+redirect -> HALT.
- Priority: rst > redirect > halt > fetch.
- In IDLE and HALT, redirect only loads pc; this is used to set the start address.
- rst mid-operation discards the held instruction and returns to IDLE at the next edge.

## Timing
- pc drives memory combinationally. The instruction at pc is in if_instr one edge after the fetch condition holds.
- start sampled at edge E0 -> RUN. Edge E1 latches the instruction at RESET_PC; if_valid is high from E1.
- Throughput is 1 instruction/cycle with if_ready held high.
- Stall: holding register and pc hold while if_valid && !if_ready.
- Redirect at edge Er: if_valid=0 after Er. The target instruction is valid after Er+1.
- halted rises the edge after the holding register empties with halt pending. It falls one edge after halt_req deasserts; fetch resumes on the following edge.

## Configuration
- FETCH_CTRL_PERF_EN defined: adds outputs fetch_cnt[15:0] and stall_cnt[15:0], both reset to 0 by rst only, wrapping.
  - fetch_cnt increments on each fetch.
  - stall_cnt increments each RUN/DRAIN cycle with if_valid && !if_ready.
- FETCH_CTRL_PERF_EN undefined: the ports and logic are absent; behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg holds PC_W, INSTR_W and the fetch_state_t enum (IDLE, RUN, DRAIN, HALT). The CPU top and bench import it.
- Optional sub-module fetch_perf_cnt (the two counters) is instantiated only under FETCH_CTRL_PERF_EN. All other logic stays flat.

## Test plan
Memory holds 1, 2, 3, 4 at addresses 0–3 for all cases.
- Reset, start, if_ready=1 -> if_instr 1,2,3,4 on consecutive cycles with if_pc 0,1,2,3; halted=0.
- if_ready=0 for 3 cycles while holding instr 2 -> if_instr=2, pc=2 held. With PERF_EN, stall_cnt=3. Release -> 3 follows next cycle.
- Redirect to 0 while holding instr 3 with if_ready=0 -> if_valid=0 next cycle, then if_instr=1, if_pc=0.
- halt_req during a stall -> DRAIN until accepted, then halted=1, pc frozen. Drop halt_req -> halted=0, fetch resumes at the frozen pc.
- In IDLE, redirect_pc=255 then start -> if_pc 255, 0, 1 (wrap-around).
- rst asserted mid-stream -> next cycle if_valid=0, pc=0, state IDLE. No fetch until start.
